// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Arbitrates the single-ported data RAM behind the MEM stage
//               between the pipeline (port P) and an external loader/debug
//               port (port L). The pipeline has default priority. A
//               starvation counter forces a loader slot after STARVE_LIMIT
//               waiting cycles, stalling the pipeline for that one cycle.
//               Loader accesses complete with a one-cycle l_ack pulse that
//               carries the read data returned by the RAM.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               over                 - halt flag, suppresses all RAM writes
//               p_valid/p_op/p_addr/p_wdata -> p_rdata, p_stall
//                                    - pipeline MEM-stage access
//               l_req/l_we/l_addr/l_wdata -> l_ack, l_rdata
//                                    - loader request/acknowledge port
//               ram_addr/ram_we/ram_wdata <- ram_rdata
//                                    - RAM control pins, 1-cycle read latency
//               conflict_cnt         - saturating count of pipeline stalls
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              over,
    input  logic              p_valid,
    input  logic [3:0]        p_op,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_wdata,
    output logic [31:0]       p_rdata,
    output logic              p_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic [31:0]       l_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int                WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] LIMIT    = WAIT_W'(STARVE_LIMIT);
    localparam logic [3:0]        OP_LOAD  = 4'b1000;
    localparam logic [3:0]        OP_STORE = 4'b1001;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LACK = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] last_addr;

    logic p_acc;
    logic p_store;
    logic starve;
    logic g_l;

    // Only the word-address bits of p_addr reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], p_addr[1:0]};

    assign p_store = (p_op == OP_STORE);
    assign p_acc   = p_valid & ((p_op == OP_LOAD) | p_store);
    assign starve  = (wait_cnt == LIMIT);

    // Loader grant. Masked by reset so nothing is issued while resetting.
    assign g_l = ~reset & l_req & (state == S_IDLE) & (~p_acc | starve);

    // A stall can only happen on a loader grant, and a grant is always
    // followed by S_LACK, so the pipeline never stalls twice in a row.
    assign p_stall = g_l & p_acc;

    // Ack is tied to the cycle after the grant; a reset landing in that
    // cycle swallows the ack so the loader re-requests.
    assign l_ack   = (state == S_LACK) & ~reset;
    assign l_rdata = l_ack ? ram_rdata : 32'h0;
    assign p_rdata = ram_rdata;

    // RAM control mux. When nobody accesses, the address holds the last
    // driven value so the RAM sees no spurious address toggling.
    always_comb begin
        ram_addr  = last_addr;
        ram_we    = 1'b0;
        ram_wdata = p_wdata;
        if (g_l) begin
            ram_addr  = l_addr;
            ram_we    = l_we & ~over;
            ram_wdata = l_wdata;
        end else if (p_acc) begin
            ram_addr  = p_addr[ADDR_W+1:2];
            ram_we    = p_store & ~over & ~reset;
            ram_wdata = p_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            conflict_cnt <= '0;
            last_addr    <= '0;
        end else begin
            case (state)
                S_IDLE:  if (g_l) state <= S_LACK;
                S_LACK:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Waiting time of the current loader request; frozen while the
            // previous loader access is being acknowledged.
            if (g_l || !l_req) begin
                wait_cnt <= '0;
            end else if ((state == S_IDLE) && (wait_cnt != LIMIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (p_stall && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end

            if (g_l || p_acc) begin
                last_addr <= ram_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter. Directed cycles
//               push hand-computed per-cycle expectations and expected loader
//               read data into queues; a monitor on the falling edge pops and
//               compares against the DUT. A small synchronous RAM model sits
//               on the RAM pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              over;
    logic              p_valid;
    logic [3:0]        p_op;
    logic [31:0]       p_addr;
    logic [31:0]       p_wdata;
    logic [31:0]       p_rdata;
    logic              p_stall;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_ack;
    logic [31:0]       l_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [CNT_W-1:0]  conflict_cnt;

    dmem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .over        (over),
        .p_valid     (p_valid),
        .p_op        (p_op),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .p_rdata     (p_rdata),
        .p_stall     (p_stall),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_ack       (l_ack),
        .l_rdata     (l_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read, one cycle latency.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[7:0]];
    end

    typedef struct packed {
        logic        stall;
        logic        ack;
        logic        we;
        logic        ca;
        logic [15:0] addr;
        logic        cw;
        logic [31:0] wd;
        logic        ccc;
        logic [3:0]  cc;
        logic        cp;
        logic [31:0] prd;
    } exp_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] val;
    } ack_t;

    exp_t cq[$];
    ack_t aq[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: per-cycle expectations plus loader ack data scoreboard.
    initial begin
        exp_t m;
        ack_t a;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                m = cq.pop_front();
                chk("p_stall", 32'(p_stall), 32'(m.stall));
                chk("l_ack",   32'(l_ack),   32'(m.ack));
                chk("ram_we",  32'(ram_we),  32'(m.we));
                if (m.ca)  chk("ram_addr",     32'(ram_addr),     32'(m.addr));
                if (m.cw)  chk("ram_wdata",    ram_wdata,         m.wd);
                if (m.ccc) chk("conflict_cnt", 32'(conflict_cnt), 32'(m.cc));
                if (m.cp)  chk("p_rdata",      p_rdata,           m.prd);
            end
            if (l_ack === 1'b1) begin
                if (aq.size() == 0) begin
                    chk("l_ack_unexpected", 32'(l_ack), 32'h0);
                end else begin
                    a = aq.pop_front();
                    if (a.chk) chk("l_rdata", l_rdata, a.val);
                end
            end
        end
    end

    task automatic drv(input logic ov, input logic pv, input logic [3:0] op,
                       input logic [31:0] pa, input logic [31:0] pw,
                       input logic lr, input logic lw, input logic [15:0] la,
                       input logic [31:0] lwd);
        over = ov; p_valid = pv; p_op = op; p_addr = pa; p_wdata = pw;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
    endtask

    task automatic ex(input logic st, input logic ak, input logic we);
        e = '0;
        e.stall = st; e.ack = ak; e.we = we;
    endtask

    task automatic exa(input logic [15:0] a);
        e.ca = 1'b1; e.addr = a;
    endtask

    task automatic excc(input int v);
        e.ccc = 1'b1; e.cc = 4'(v);
    endtask

    task automatic step();
        cq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h55AA55AA;
        reset = 1'b1;
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        @(posedge clk);
        #1;

        // Reset state
        repeat (2) begin
            ex(0, 0, 0); excc(0); step();
        end
        reset = 1'b0;

        // Idle pipeline, loader read of 0x0010
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 16'h0010, 32'h0);
        ex(0, 0, 0); exa(16'h0010); aq.push_back({1'b1, 32'hDEADBEEF}); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 1, 0); step();

        // Pipeline store, then the same under over, then idle address hold
        drv(0, 1, 4'h9, 32'h00000044, 32'h12345678, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 1); exa(16'h0011); e.cw = 1'b1; e.wd = 32'h12345678; step();
        drv(1, 1, 4'h9, 32'h00000044, 32'h12345678, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 0); exa(16'h0011); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 0); exa(16'h0011); step();

        // Loader write under over: no write, still acked
        drv(1, 0, 4'h0, 32'h0, 32'h0, 1, 1, 16'h0020, 32'hCAFEF00D);
        ex(0, 0, 0); exa(16'h0020); e.cw = 1'b1; e.wd = 32'hCAFEF00D;
        aq.push_back({1'b0, 32'h0}); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 1, 0); step();
        // Read it back: original contents must remain
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 16'h0020, 32'h0);
        ex(0, 0, 0); exa(16'h0020); aq.push_back({1'b1, 32'h55AA55AA}); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 1, 0); step();

        // Back-to-back loader reads: no grant in the ack cycle
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 16'h0010, 32'h0);
        ex(0, 0, 0); exa(16'h0010); aq.push_back({1'b1, 32'hDEADBEEF}); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 16'h0011, 32'h0);
        ex(0, 1, 0); exa(16'h0010); step();
        ex(0, 0, 0); exa(16'h0011); aq.push_back({1'b1, 32'h12345678}); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 1, 0); exa(16'h0011); step();

        // Starvation: continuous pipeline loads of word 0x20, loader at 0x11
        for (int k = 0; k < 4; k++) begin
            drv(0, 1, 4'h8, 32'h00000080, 32'h0, 1, 0, 16'h0011, 32'h0);
            ex(0, 0, 0); exa(16'h0020); excc(0);
            if (k > 0) begin e.cp = 1'b1; e.prd = 32'h55AA55AA; end
            step();
        end
        ex(1, 0, 0); exa(16'h0011); excc(0); e.cp = 1'b1; e.prd = 32'h55AA55AA;
        aq.push_back({1'b1, 32'h12345678}); step();
        drv(0, 1, 4'h8, 32'h00000080, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 1, 0); exa(16'h0020); excc(1); step();
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 0); excc(1); e.cp = 1'b1; e.prd = 32'h55AA55AA; step();

        // Reset in the ack cycle: ack suppressed, counters cleared
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 16'h0010, 32'h0);
        ex(0, 0, 0); exa(16'h0010); step();
        reset = 1'b1;
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 0); excc(1); step();
        reset = 1'b0;
        ex(0, 0, 0); excc(0); step();

        // Saturation of the 4-bit conflict counter over 17 forced stalls
        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < 6; k++) begin
                drv(0, 1, 4'h8, 32'h00000080, 32'h0, 1, 0, 16'h0010, 32'h0);
                ex(k == 4, k == 5, 0);
                exa((k == 4) ? 16'h0010 : 16'h0020);
                excc((k == 5) ? sat15(i + 1) : sat15(i));
                if (k == 4) aq.push_back({1'b1, 32'hDEADBEEF});
                step();
            end
        end
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 16'h0, 32'h0);
        ex(0, 0, 0); excc(15); step();

        chk("ack_queue_left", 32'(aq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data RAM behind the MEM stage between two requesters:
  - Port P: the pipeline MEM stage (load/store ops on the ex-bus).
  - Port L: an external loader/debug port (program load, memory inspection).
- Pipeline has default priority. A starvation counter guarantees the loader a slot, stalling the pipeline for that cycle.
- Owns the RAM control pins (addr/we/wdata). Returns loader read data through a request/acknowledge handshake.

Parameters:
- ADDR_W, 16, word-address width into the data RAM (byte address bits [ADDR_W+1:2]).
- STARVE_LIMIT, 4, cycles the loader may wait before it is forced a slot (1..15).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- over  in  1  halt flag; while high, all RAM writes are suppressed.
- p_valid  in  1  MEM-stage op valid.
- p_op  in  4  op code: 4'b1000 = load, 4'b1001 = store, others = no RAM access.
- p_addr  in  32  byte address; bits [ADDR_W+1:2] are used.
- p_wdata  in  32  store data.
- p_rdata  out  32  load data for pipeline; equals ram_rdata.
- p_stall  out  1  pipeline must hold its MEM-stage op this cycle.
- l_req  in  1  loader request; held high until l_ack.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  32  loader write data.
- l_ack  out  1  one-cycle completion pulse.
- l_rdata  out  32  loader read data, valid while l_ack=1.
- ram_addr  out  ADDR_W  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, one-cycle synchronous read latency.
- conflict_cnt  out  CNT_W  saturating count of cycles with p_stall=1.

Behaviour:
- Reset: state=S_IDLE, wait_cnt=0, conflict_cnt=0, l_ack=0, l_rdata=0. While reset is high, ram_we=0 and p_stall=0.
- Definitions:
  - p_acc = p_valid & (p_op==4'b1000 | p_op==4'b1001).
  - starve = (wait_cnt==STARVE_LIMIT).
- States: S_IDLE, S_LACK (a loader access was issued last cycle; ack is due).
- Loader grant in cycle t, combinational: g_l = l_req & (state==S_IDLE) & (~p_acc | starve).
- RAM drive:
  - If g_l: ram_addr=l_addr, ram_we=l_we&~over, ram_wdata=l_wdata.
  - Else if p_acc: ram_addr=p_addr[ADDR_W+1:2], ram_we=(p_op==4'b1001)&~over, ram_wdata=p_wdata.
  - Else: ram_we=0; ram_addr holds the last driven value.
- p_stall = g_l & p_acc. A stalled op keeps p_valid/p_op/p_addr/p_wdata stable and is served the next cycle. The next cycle is S_LACK, where the loader cannot be granted, so the pipeline is never stalled two cycles in a row.
- FSM:
  - S_IDLE -> S_LACK on g_l.
  - S_LACK -> S_IDLE unconditionally.
  - In S_LACK: l_ack=1 and l_rdata=ram_rdata; for a write, l_rdata is don't-care (drive ram_rdata anyway).
  - Loader throughput is at most one access per 2 cycles. l_req seen in the ack cycle is a new request.
- wait_cnt:
  - Cleared on g_l or when ~l_req.
  - Increments by 1 when l_req & ~g_l & state==S_IDLE, saturating at STARVE_LIMIT.
  - Holds in S_LACK.
- conflict_cnt: +1 each cycle p_stall=1; saturates at all-ones.
- p_rdata = ram_rdata, unregistered. The pipeline samples it the cycle after issuing a non-stalled load.
- over=1: grants, acks and address muxing are unchanged; only ram_we is forced 0. A loader write under over still acks.
- Simultaneous l_req rise and p_acc with wait_cnt=0: pipeline wins; wait_cnt=1 next cycle.
- Reset mid-access (in S_LACK): no l_ack is produced; the loader must re-request.

Test Plan:
- Idle pipeline; loader read of addr 0x0010 with ram_rdata=0xDEADBEEF in the next cycle -> grant same cycle, ram_we=0, l_ack one cycle later with l_rdata=0xDEADBEEF, p_stall never 1.
- Continuous pipeline loads plus l_req held, STARVE_LIMIT=4 -> pipeline served 4 cycles, 5th cycle p_stall=1 with ram_addr=l_addr, l_ack the next cycle, conflict_cnt=1, stalled load served in the ack cycle.
- Pipeline store p_addr=0x00000044, p_wdata=0x12345678, no loader -> ram_addr=0x0011, ram_we=1, ram_wdata=0x12345678; repeat with over=1 -> ram_we=0.
- Loader write under over=1 -> ram_we=0, l_ack still pulses after 1 cycle.
- Back-to-back loader requests with idle pipeline -> acks every 2nd cycle, never granted in the S_LACK cycle.
- Reset asserted in S_LACK -> l_ack=0 next cycle, wait_cnt=0, conflict_cnt=0; conflict_cnt forced near all-ones (CNT_W=4, 15 stalls) -> stays at 15.
